lock_ctrl: RTL and testbench

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_pkg.sv | 31 +++
 rtl/lock_ctrl_if.sv | 25 ++
 rtl/lock_timer.sv | 34 +++
 rtl/lock_ctrl.sv | 134 +++++++++++++
 tb/tb_lock_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared types and default constants for the keypad lock controller.
// Also holds the digit-validity helper used when programming a new code.
package lock_pkg;

    typedef enum logic [1:0] {
        LOCKED,
        UNLOCKED,
        PROG_WAIT,
        LOCKOUT
    } lock_state_e;

    localparam logic [15:0] DEFAULT_CODE_C   = 16'h1234;
    localparam int          UNLOCK_CYCLES_C  = 1250;
    localparam int          LOCKOUT_CYCLES_C = 7500;
    localparam int          PROG_CYCLES_C    = 3750;
    localparam int          MAX_FAILS_C      = 3;
    localparam int          TIMER_W          = 13;

    // Digits E and F are reserved keys and may not appear in a stored code.
    function automatic logic has_bad_nibble(logic [15:0] c);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (c[4*i +: 4] >= 4'hE) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/lock_ctrl_if.sv
// Keypad-side bundle: entered code, programming request and lock status.
// The driver of the keypad is the master; the lock controller is the slave.
interface lock_ctrl_if;
    logic        start;
    logic [15:0] code_in;
    logic        prog_req;
    logic        unlock;
    logic        alarm;
    logic        prog_mode;
    logic [1:0]  fail_cnt;
    logic        code_changed;
    logic        code_reject;

    modport master (
        output start, code_in, prog_req,
        input  unlock, alarm, prog_mode, fail_cnt,
        input  code_changed, code_reject
    );

    modport slave (
        input  start, code_in, prog_req,
        output unlock, alarm, prog_mode, fail_cnt,
        output code_changed, code_reject
    );
endinterface

// File: rtl/lock_timer.sv
// 13-bit down-counter with synchronous load; holds at zero once it gets there.
// The zero flag reflects the current count.
module lock_timer
    import lock_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!zero) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock: code compare, failure lockout and code reprogramming.
// All status outputs are registered copies of the next-state decode.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter logic [15:0] DEFAULT_CODE   = DEFAULT_CODE_C,
    parameter int          UNLOCK_CYCLES  = UNLOCK_CYCLES_C,
    parameter int          LOCKOUT_CYCLES = LOCKOUT_CYCLES_C,
    parameter int          PROG_CYCLES    = PROG_CYCLES_C,
    parameter int          MAX_FAILS      = MAX_FAILS_C
) (
    input logic         clk,
    input logic         rst,
    lock_ctrl_if.slave  bus
);

    // Loading N-1 makes a state last exactly N cycles: it exits on zero.
    localparam logic [TIMER_W-1:0] UNLOCK_LD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PROG_LD    = TIMER_W'(PROG_CYCLES - 1);
    localparam logic [1:0]         MAX_LD     = 2'(MAX_FAILS);

    lock_state_e        state_q, state_d;
    logic [15:0]        code_q, code_d;
    logic [1:0]         fail_q, fail_d;
    logic               unlock_q, unlock_d;
    logic               alarm_q, alarm_d;
    logic               prog_q, prog_d;
    logic               changed_q, changed_d;
    logic               reject_q, reject_d;
    logic               t_load;
    logic [TIMER_W-1:0] t_val;
    logic               t_zero;

    lock_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        fail_d    = fail_q;
        t_load    = 1'b0;
        t_val     = '0;
        changed_d = 1'b0;
        reject_d  = 1'b0;
        case (state_q)
            LOCKED: begin
                if (bus.start) begin
                    if (bus.code_in == code_q) begin
                        state_d = UNLOCKED;
                        t_load  = 1'b1;
                        t_val   = UNLOCK_LD;
                        fail_d  = '0;
                    end else begin
                        fail_d = (fail_q == 2'd3) ? fail_q : fail_q + 2'd1;
                        if (fail_d >= MAX_LD) begin
                            state_d = LOCKOUT;
                            t_load  = 1'b1;
                            t_val   = LOCKOUT_LD;
                        end
                    end
                end
            end
            UNLOCKED: begin
                if (t_zero) begin
                    state_d = LOCKED;
                end else if (bus.prog_req) begin
                    state_d = PROG_WAIT;
                    t_load  = 1'b1;
                    t_val   = PROG_LD;
                end
            end
            PROG_WAIT: begin
                if (bus.start) begin
                    state_d = LOCKED;
                    t_load  = 1'b1;
                    if (has_bad_nibble(bus.code_in)) begin
                        reject_d = 1'b1;
                    end else begin
                        code_d    = bus.code_in;
                        changed_d = 1'b1;
                    end
                end else if (t_zero) begin
                    state_d = LOCKED;
                end
            end
            LOCKOUT: begin
                if (t_zero) begin
                    state_d = LOCKED;
                    fail_d  = '0;
                end
            end
            default: state_d = LOCKED;
        endcase
        unlock_d = (state_d == UNLOCKED);
        alarm_d  = (state_d == LOCKOUT);
        prog_d   = (state_d == PROG_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOCKED;
            code_q    <= DEFAULT_CODE;
            fail_q    <= '0;
            unlock_q  <= 1'b0;
            alarm_q   <= 1'b0;
            prog_q    <= 1'b0;
            changed_q <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            fail_q    <= fail_d;
            unlock_q  <= unlock_d;
            alarm_q   <= alarm_d;
            prog_q    <= prog_d;
            changed_q <= changed_d;
            reject_q  <= reject_d;
        end
    end

    assign bus.unlock       = unlock_q;
    assign bus.alarm        = alarm_q;
    assign bus.prog_mode    = prog_q;
    assign bus.fail_cnt     = fail_q;
    assign bus.code_changed = changed_q;
    assign bus.code_reject  = reject_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: remaining-time model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lock_ctrl;

    localparam int UNLOCK_N  = 1250;
    localparam int LOCKOUT_N = 7500;
    localparam int PROG_N    = 3750;
    localparam int MAX_F     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;

    lock_ctrl_if bus ();

    lock_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: how many cycles each timed condition still has to run.
    int          m_unlock_left = 0;
    int          m_prog_left   = 0;
    int          m_alarm_left  = 0;
    int          m_fails       = 0;
    logic [15:0] m_code        = 16'h1234;
    bit          m_chg         = 1'b0;
    bit          m_rej         = 1'b0;

    function automatic int sat_inc(int f);
        return (f >= 3) ? 3 : f + 1;
    endfunction

    function automatic bit bad_digit(logic [15:0] c);
        bit b;
        b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (((c >> (4 * i)) & 16'hF) >= 16'hE) b = 1'b1;
        end
        return b;
    endfunction

    always @(posedge clk) begin
        m_chg <= 1'b0;
        m_rej <= 1'b0;
        if (rst) begin
            m_unlock_left <= 0;
            m_prog_left   <= 0;
            m_alarm_left  <= 0;
            m_fails       <= 0;
            m_code        <= 16'h1234;
        end else if (m_unlock_left > 0) begin
            if (m_unlock_left == 1) begin
                m_unlock_left <= 0;
            end else if (bus.prog_req) begin
                m_unlock_left <= 0;
                m_prog_left   <= PROG_N;
            end else begin
                m_unlock_left <= m_unlock_left - 1;
            end
        end else if (m_prog_left > 0) begin
            if (bus.start) begin
                m_prog_left <= 0;
                if (bad_digit(bus.code_in)) begin
                    m_rej <= 1'b1;
                end else begin
                    m_chg  <= 1'b1;
                    m_code <= bus.code_in;
                end
            end else begin
                m_prog_left <= m_prog_left - 1;
            end
        end else if (m_alarm_left > 0) begin
            m_alarm_left <= m_alarm_left - 1;
            if (m_alarm_left == 1) m_fails <= 0;
        end else if (bus.start) begin
            if (bus.code_in == m_code) begin
                m_unlock_left <= UNLOCK_N;
                m_fails       <= 0;
            end else begin
                m_fails <= sat_inc(m_fails);
                if (sat_inc(m_fails) >= MAX_F) m_alarm_left <= LOCKOUT_N;
            end
        end
    end

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_unlock", 16'(bus.unlock), 16'(m_unlock_left > 0));
            check("m_alarm", 16'(bus.alarm), 16'(m_alarm_left > 0));
            check("m_prog", 16'(bus.prog_mode), 16'(m_prog_left > 0));
            check("m_fail", 16'(bus.fail_cnt), 16'(m_fails));
            check("m_chg", 16'(bus.code_changed), 16'(m_chg));
            check("m_rej", 16'(bus.code_reject), 16'(m_rej));
        end
    end

    // Caller is at a negedge; returns at the negedge showing the response.
    task automatic pulse(logic [15:0] c);
        bus.start   = 1'b1;
        bus.code_in = c;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.code_in = 16'h0000;
    endtask

    task automatic enter_prog();
        bus.prog_req = 1'b1;
        @(negedge clk);
        bus.prog_req = 1'b0;
    endtask

    task automatic wait_unlock_end();
        int k;
        k = 0;
        while (bus.unlock && k < 5000) begin
            k++;
            @(negedge clk);
        end
        check("unlock_end", 16'(bus.unlock), 16'h0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.code_in  = 16'h0000;
        bus.prog_req = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_unlock", 16'(bus.unlock), 16'h0);
        check("rst_alarm", 16'(bus.alarm), 16'h0);
        check("rst_prog", 16'(bus.prog_mode), 16'h0);
        check("rst_fail", 16'(bus.fail_cnt), 16'h0);

        pulse(16'h1234);
        check("unlock_next", 16'(bus.unlock), 16'h1);
        n = 0;
        while (bus.unlock && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("unlock_len", 16'(n), 16'(UNLOCK_N));

        pulse(16'h0000);
        check("fail1", 16'(bus.fail_cnt), 16'h1);
        pulse(16'h0000);
        check("fail2", 16'(bus.fail_cnt), 16'h2);
        pulse(16'h0000);
        check("alarm_on", 16'(bus.alarm), 16'h1);
        check("fail3", 16'(bus.fail_cnt), 16'h3);
        pulse(16'h1234);
        check("lockout_ign", 16'(bus.unlock), 16'h0);
        n = 1;
        while (bus.alarm && n < 10000) begin
            n++;
            @(negedge clk);
        end
        check("alarm_len", 16'(n), 16'(LOCKOUT_N));
        check("fail_clr", 16'(bus.fail_cnt), 16'h0);

        pulse(16'h1234);
        enter_prog();
        check("prog_on", 16'(bus.prog_mode), 16'h1);
        pulse(16'h12E4);
        check("reject", 16'(bus.code_reject), 16'h1);
        pulse(16'h1234);
        check("still_1234", 16'(bus.unlock), 16'h1);
        wait_unlock_end();

        pulse(16'h1234);
        repeat (UNLOCK_N - 1) @(negedge clk);
        check("last_unlock", 16'(bus.unlock), 16'h1);
        enter_prog();
        check("expiry_wins", 16'(bus.prog_mode), 16'h0);

        pulse(16'h1234);
        enter_prog();
        n = 0;
        while (bus.prog_mode && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("prog_len", 16'(n), 16'(PROG_N));
        pulse(16'h1234);
        check("prog_tmo_code", 16'(bus.unlock), 16'h1);
        wait_unlock_end();

        pulse(16'h1234);
        enter_prog();
        repeat (PROG_N - 1) @(negedge clk);
        check("prog_last", 16'(bus.prog_mode), 16'h1);
        pulse(16'hF000);
        check("start_wins", 16'(bus.code_reject), 16'h1);

        pulse(16'h1234);
        enter_prog();
        pulse(16'h5678);
        check("changed", 16'(bus.code_changed), 16'h1);
        pulse(16'h5678);
        check("new_unlock", 16'(bus.unlock), 16'h1);
        wait_unlock_end();
        pulse(16'h1234);
        check("old_fails", 16'(bus.fail_cnt), 16'h1);

        pulse(16'h5678);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid", 16'(bus.unlock), 16'h0);
        pulse(16'h1234);
        check("rst_default", 16'(bus.unlock), 16'h1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
